sc_vehicle_lane_shifter: RTL

Downstream consumer of the vehicle-level state machine: holds one 8-cell lane of vehicles, loads the level pattern when the state machine requests a load, then rotates it one cell per speed tick. The speed tick comes from an internal prescaler whose terminal count is chosen by the speed-select line. A sticky collision flag is raised when an occupied cell overlaps the frog's position mask. Lane output feeds the display/matrix driver; the collision flag feeds the game-state logic.

---
 rtl/sc_vehicle_lane_shifter_pkg.sv | 9 +
 rtl/sc_vel_prescaler.sv | 31 +++
 rtl/sc_vehicle_lane_shifter.sv | 62 ++++++
 3 files changed

// File: rtl/sc_vehicle_lane_shifter_pkg.sv
// sc_vehicle_lane_shifter_pkg: shared defaults and rotation-direction encodings for the vehicle lane shifter
package sc_vehicle_lane_shifter_pkg;
  localparam int DATAWIDTH_BUS_DEF = 8;
  localparam int PRESC_WIDTH_DEF   = 26;
  localparam int PRESC_SEL1_DEF    = 25000000;
  localparam int PRESC_SEL0_DEF    = 12500000;
  localparam int DIR_TO_MSB        = 0;
  localparam int DIR_TO_LSB        = 1;
endpackage

// File: rtl/sc_vel_prescaler.sv
// sc_vel_prescaler: speed prescaler, counts enabled cycles and fires when the selected limit is reached
//   clk/rst : clock, async active-high reset
//   clr     : clear counter (load), overrides enable
//   en      : count enable
//   sel     : 1 = PRESC_SEL1 limit, 0 = PRESC_SEL0 limit
//   fire    : combinational, high on the enabled cycle the counter wraps
module sc_vel_prescaler
  import sc_vehicle_lane_shifter_pkg::*;
#(
  parameter int PRESC_WIDTH = PRESC_WIDTH_DEF,
  parameter int PRESC_SEL1  = PRESC_SEL1_DEF,
  parameter int PRESC_SEL0  = PRESC_SEL0_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sel,
  output logic fire
);
  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d, last;
  // >= rather than == so a switch to a shorter limit mid-count fires instead of wrapping
  always_comb begin
    last  = sel ? PRESC_WIDTH'(PRESC_SEL1 - 1) : PRESC_WIDTH'(PRESC_SEL0 - 1);
    fire  = !clr && en && (cnt_q >= last);
    cnt_d = (clr || fire) ? '0 : en ? cnt_q + PRESC_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/sc_vehicle_lane_shifter.sv
// sc_vehicle_lane_shifter: one circular lane of vehicles, loaded from a pattern and rotated per speed tick, with sticky frog collision
//   SC_VEHICLE_LANE_CLOCK_50 / SC_VEHICLE_LANE_RESET : clock, async active-high reset
//   SC_VEHICLE_LANE_LOAD_IN / PATTERN_IN             : load pattern, clear prescaler and collision
//   SC_VEHICLE_LANE_VEL_SELECT_IN / HAB_VEL_IN       : speed select, shift enable
//   SC_VEHICLE_LANE_FROG_MASK_IN                     : frog cell in this lane
//   SC_VEHICLE_LANE_LANE_OUT / TICK_OUT / COLLISION_OUT : registered lane, shift pulse, sticky overlap
module sc_vehicle_lane_shifter
  import sc_vehicle_lane_shifter_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
  parameter int PRESC_WIDTH   = PRESC_WIDTH_DEF,
  parameter int PRESC_SEL1    = PRESC_SEL1_DEF,
  parameter int PRESC_SEL0    = PRESC_SEL0_DEF,
  parameter int DIRECTION     = DIR_TO_MSB
) (
  input  logic                     SC_VEHICLE_LANE_CLOCK_50,
  input  logic                     SC_VEHICLE_LANE_RESET,
  input  logic                     SC_VEHICLE_LANE_LOAD_IN,
  input  logic [DATAWIDTH_BUS-1:0] SC_VEHICLE_LANE_PATTERN_IN,
  input  logic                     SC_VEHICLE_LANE_VEL_SELECT_IN,
  input  logic                     SC_VEHICLE_LANE_HAB_VEL_IN,
  input  logic [DATAWIDTH_BUS-1:0] SC_VEHICLE_LANE_FROG_MASK_IN,
  output logic [DATAWIDTH_BUS-1:0] SC_VEHICLE_LANE_LANE_OUT,
  output logic                     SC_VEHICLE_LANE_TICK_OUT,
  output logic                     SC_VEHICLE_LANE_COLLISION_OUT
);
  localparam int W = DATAWIDTH_BUS;
  logic [W-1:0] lane_q, lane_d, rot;
  logic         tick_q, tick_d, coll_q, coll_d, fire;
  sc_vel_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH),
    .PRESC_SEL1 (PRESC_SEL1),
    .PRESC_SEL0 (PRESC_SEL0)
  ) u_presc (
    .clk (SC_VEHICLE_LANE_CLOCK_50),
    .rst (SC_VEHICLE_LANE_RESET),
    .clr (SC_VEHICLE_LANE_LOAD_IN),
    .en  (SC_VEHICLE_LANE_HAB_VEL_IN),
    .sel (SC_VEHICLE_LANE_VEL_SELECT_IN),
    .fire(fire)
  );
  // collision looks at the registered lane, not the value about to be shifted in
  always_comb begin
    rot    = (DIRECTION == DIR_TO_LSB) ? {lane_q[0], lane_q[W-1:1]} : {lane_q[W-2:0], lane_q[W-1]};
    lane_d = SC_VEHICLE_LANE_LOAD_IN ? SC_VEHICLE_LANE_PATTERN_IN : fire ? rot : lane_q;
    tick_d = fire;
    coll_d = SC_VEHICLE_LANE_LOAD_IN ? 1'b0 : coll_q | (|(lane_q & SC_VEHICLE_LANE_FROG_MASK_IN));
  end
  always_ff @(posedge SC_VEHICLE_LANE_CLOCK_50 or posedge SC_VEHICLE_LANE_RESET)
    if (SC_VEHICLE_LANE_RESET) begin
      lane_q <= '0;
      tick_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      tick_q <= tick_d;
      coll_q <= coll_d;
    end
  assign SC_VEHICLE_LANE_LANE_OUT      = lane_q;
  assign SC_VEHICLE_LANE_TICK_OUT      = tick_q;
  assign SC_VEHICLE_LANE_COLLISION_OUT = coll_q;
endmodule
